// File: rtl/fifo_rr_sched.sv
// rtl/fifo_rr_sched.sv - round-robin burst read scheduler, four input FIFOs into one output FIFO
//
// Purpose: pops up to MAX_BURST words per grant from four 4-bit input FIFOs and
// forwards each popped word as a write into a shared output FIFO. Free output
// slots are tracked with a credit counter, so the output FIFO's full flags are
// never consulted.
//
// Optional feature (macro FIFO_SCHED_PRIO_EN): channel 0 wins every arbitration
// it takes part in; channels 1-3 round-robin among themselves. A channel 0 grant
// leaves the round-robin pointer untouched. Default build: pure 4-way round robin.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   sched_en       1 allows bursts to start and reads to issue
//   in_empty[3:0]  buf_empty of input FIFO i on bit i
//   in_data[15:0]  buf_out of input FIFO i on bits [4i+3:4i]
//   in_rd_en[3:0]  one-hot rd_en to the input FIFOs (combinational)
//   out_pop        one pulse per word removed from the output FIFO
//   out_wr_en      registered wr_en to the output FIFO
//   out_data[3:0]  buf_in of the output FIFO, in_data lane of the write channel
//   grant[1:0]     currently granted channel
//   busy           burst in progress or write pending
//   credits[4:0]   free output-FIFO slots as seen by the scheduler

module fifo_rr_sched #(
  parameter int MAX_BURST = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sched_en,
  input  logic [3:0]  in_empty,
  input  logic [15:0] in_data,
  output logic [3:0]  in_rd_en,
  input  logic        out_pop,
  output logic        out_wr_en,
  output logic [3:0]  out_data,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [4:0]  credits
);

  localparam logic [3:0] BURST_MAX = MAX_BURST[3:0];
  localparam logic [4:0] DEPTH     = OUT_DEPTH[4:0];

`ifdef FIFO_SCHED_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [4:0] credits_q, credits_d;
  logic       wr_en_q;
  logic [1:0] wr_ch_q;

  logic       issue;
  logic       pop_eff;
  logic       have_credit;
  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;

  assign have_credit = (credits_q != 5'd0);
  // A pop while every slot is already free cannot correspond to a real word.
  assign pop_eff     = out_pop && (credits_q < DEPTH);

  // Arbitration: first non-empty channel after last_q. With priority enabled,
  // channel 0 is taken first and is skipped by the rotating search.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = 2'd0;
    if (PRIO_EN && !in_empty[0]) begin
      pick  = 2'd0;
      found = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        cand = last_q + 2'(k);
        if (!found && !in_empty[cand] && !(PRIO_EN && cand == 2'd0)) begin
          pick  = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    issue       = 1'b0;
    in_rd_en    = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (sched_en && have_credit && found) begin
          grant_d     = pick;
          burst_cnt_d = 4'd0;
          state_d     = S_BURST;
        end
      end
      S_BURST: begin
        issue = sched_en && !in_empty[grant_q] && have_credit && (burst_cnt_q < BURST_MAX);
        if (issue) begin
          in_rd_en[grant_q] = 1'b1;
          burst_cnt_d       = burst_cnt_q + 4'd1;
        end
        // A burst ends on the first cycle that cannot issue, or on its last word.
        if (!issue || burst_cnt_d == BURST_MAX) begin
          state_d = S_IDLE;
          if (!(PRIO_EN && grant_q == 2'd0)) begin
            last_d = grant_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    if (issue && !pop_eff) begin
      credits_d = credits_q - 5'd1;
    end else if (!issue && pop_eff) begin
      credits_d = credits_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'd0;
      last_q      <= 2'd3;
      burst_cnt_q <= 4'd0;
      credits_q   <= DEPTH;
      wr_en_q     <= 1'b0;
      wr_ch_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      credits_q   <= credits_d;
      wr_en_q     <= issue;
      if (issue) begin
        wr_ch_q <= grant_q;
      end
    end
  end

  // The input FIFO presents the popped word the cycle after rd_en, which is
  // exactly when the registered write strobe is high.
  always_comb begin
    case (wr_ch_q)
      2'd0:    out_data = in_data[3:0];
      2'd1:    out_data = in_data[7:4];
      2'd2:    out_data = in_data[11:8];
      default: out_data = in_data[15:12];
    endcase
  end

  assign out_wr_en = wr_en_q;
  assign grant     = grant_q;
  assign busy      = (state_q == S_BURST) || wr_en_q;
  assign credits   = credits_q;

endmodule

// File: doc/fifo_rr_sched.md
# fifo_rr_sched

Round-robin read scheduler that drains four 4-bit input FIFOs into one shared output FIFO.
- Sequences `rd_en` on the input FIFOs in bursts and forwards each popped word as a write into the output FIFO.
- Tracks output-FIFO occupancy with a credit counter, so it never relies on the output FIFO's equality-based `almost_full`/`buf_full` flags.
- Sits between the per-lane `fifo` instances and the merged downstream path.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum words read from one channel per grant (1..15).
- `OUT_DEPTH`, default 8: output FIFO capacity in words; initial credit value (1..16).

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sched_en` in 1: when 0, no new burst starts and no further reads issue.
- `in_empty` in 4: `buf_empty` of input FIFO *i* on bit *i*.
- `in_data` in 16: `buf_out` of input FIFO *i* on bits [4i+3:4i].
- `in_rd_en` out 4: one-hot `rd_en` to input FIFO *i*; combinational.
- `out_pop` in 1: one-cycle pulse per word actually removed from the output FIFO (downstream `rd_en && !buf_empty`).
- `out_wr_en` out 1: registered; `wr_en` to the output FIFO.
- `out_data` out 4: `buf_in` of the output FIFO; mux of `in_data` selected by the registered write channel.
- `grant` out 2: channel currently granted.
- `busy` out 1: 1 while in BURST or while a write is pending.
- `credits` out 5: free output-FIFO slots as seen by the scheduler.

## Operation
- **State machine:** two states, IDLE and BURST.
- **IDLE:**
  - If `sched_en`, `credits > 0` and any `!in_empty[i]`: pick the next non-empty channel searching from `last+1` mod 4.
  - Register the pick in `grant`, clear `burst_cnt`, go to BURST.
  - Otherwise stay in IDLE.
- **BURST:**
  - Issue condition: `sched_en && !in_empty[grant] && credits > 0 && burst_cnt < MAX_BURST`.
  - When the issue condition holds, `in_rd_en[grant] = 1` and `burst_cnt++`.
  - Leave for IDLE when no issue happens this cycle, or when this issue makes `burst_cnt == MAX_BURST`.
  - On exit, `last <= grant`.
- **Write forwarding:** each issue at cycle t sets `out_wr_en = 1` and `wr_ch = grant` at edge t+1. The input FIFO `buf_out` is valid from t+1, so `out_data = in_data[wr_ch]`, and the output FIFO captures it at edge t+2.
- **Credits:**
  - Reset to `OUT_DEPTH`.
  - −1 per issue, +1 per `out_pop`; both in the same cycle leaves the value unchanged.
  - Saturates at `OUT_DEPTH`; an `out_pop` with credits already at `OUT_DEPTH` is ignored.
  - Never goes below 0, because issue is gated by `credits > 0`.
- **Round robin:** `last` resets to 3, so channel 0 is served first after reset.
- **`in_rd_en`:** never asserted for an empty FIFO and never more than one bit at a time.

## Timing
- **Reset values:** `in_rd_en = 0`, `out_wr_en = 0`, `out_data = in_data[3:0]` (because `wr_ch` resets to 0), `grant = 0`, `busy = 0`, `credits = OUT_DEPTH`, state IDLE, `last = 3`, `burst_cnt = 0`.
- **Latency:**
  - Non-empty input to first `in_rd_en`: 1 cycle (the IDLE decision cycle).
  - Issue to `out_wr_en`: 1 cycle.
- **Throughput:** 1 word/cycle within a burst; one dead cycle (IDLE) between bursts.
- **Input FIFO drains mid-burst:** `in_empty` updates the cycle after the last read, so no extra read issues; the burst ends.
- **Credits reach 0 mid-burst:** the burst ends. Re-arbitration happens once credits > 0.
- **`sched_en` falls mid-burst:** no further reads issue, and the burst ends at that cycle. The pending `out_wr_en` still completes.
- **`rst` mid-burst:** the pending write is dropped (`out_wr_en = 0` after the edge), credits reload to `OUT_DEPTH`, and any in-flight input pop is lost. The input FIFOs are expected to share the same reset.

## Configuration
- **`FIFO_SCHED_PRIO_EN` defined:**
  - In IDLE, channel 0 wins whenever `!in_empty[0]`; channels 1–3 round-robin among themselves.
  - A channel 0 grant does not update `last`.
  - Bursts are never preempted.
- **`FIFO_SCHED_PRIO_EN` undefined:** pure 4-way round robin as described above.

## Test plan
- **Single word:** after reset, ch2 holds 1 word 0xA. Required: `in_rd_en = 4'b0100` for exactly 1 cycle, `out_wr_en` 1 cycle later with `out_data = 0xA`, `credits` 8→7.
- **Burst limit:** ch0 and ch1 each hold 6 words, `MAX_BURST = 4`. Required grant order: ch0×4, ch1×4, ch0×2, ch1×2, with one IDLE cycle between bursts.
- **Credit stall:** `OUT_DEPTH = 8`, no `out_pop`, ch3 holds 12 words. Required: exactly 8 reads, then stall with `credits = 0`; one `out_pop` pulse gives exactly 1 more read.
- **Simultaneous issue and pop:** `out_pop` pulses in the same cycle as an issue. Required: `credits` unchanged.
- **Enable and reset mid-burst:** drop `sched_en` during the 2nd word of a burst: no 3rd read, and the pending write completes. Repeat with `rst`: `out_wr_en = 0`, `credits = 8` the next cycle.
- **Priority (`FIFO_SCHED_PRIO_EN` defined):** ch0 refilled every burst while ch1 and ch2 are non-empty. Required: ch0 granted at every IDLE decision; ch1 and ch2 alternate only when ch0 is empty.
